// File: rtl/offload_pkg.sv
// Shared types and constants for the host-offload sequencer.
package offload_pkg;

    // Sequencer states: idle, waiting on the compute core, waiting to hand off
    // to the sender, and waiting for the sender to finish.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam int DEF_PACKET_SIZE = 15;
    localparam int PKT_CNT_W       = 16;
    localparam int ERR_CNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on inc unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/offload_sequencer.sv
// Sequences one host-offload job: receiver packet -> compute core -> sender,
// with debug counters for completed jobs, dropped packets and compute timeouts.
module offload_sequencer
    import offload_pkg::*;
#(
    parameter int PACKET_SIZE   = DEF_PACKET_SIZE,
    parameter int COMP_TIMEOUT  = 1024,
    parameter int TX_START_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*PACKET_SIZE-1:0] rx_packet,
    input  logic                     rx_ready,
    output logic [8*PACKET_SIZE-1:0] comp_in,
    output logic                     comp_start,
    input  logic [8*PACKET_SIZE-1:0] comp_out,
    input  logic                     comp_done,
    output logic [8*PACKET_SIZE-1:0] tx_packet,
    output logic                     tx_enable,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic [PKT_CNT_W-1:0]     pkt_cnt,
    output logic [ERR_CNT_W-1:0]     overrun_cnt,
    output logic [ERR_CNT_W-1:0]     timeout_cnt
);

    localparam int PW = 8 * PACKET_SIZE;
    localparam int TW = $clog2(COMP_TIMEOUT + 1);
    localparam int WW = $clog2(TX_START_WAIT + 1);

    localparam logic [TW-1:0]        TIMER_LAST = TW'(COMP_TIMEOUT - 1);
    localparam logic [WW-1:0]        WCNT_LAST  = WW'(TX_START_WAIT - 1);
    localparam logic [TW-1:0]        TIMER_ONE  = TW'(1'b1);
    localparam logic [WW-1:0]        WCNT_ONE   = WW'(1'b1);
    localparam logic [PKT_CNT_W-1:0] PKT_ONE    = PKT_CNT_W'(1'b1);

    state_e               state_q,      state_d;
    logic                 rx_prev_q,    rx_prev_d;
    logic [PW-1:0]        comp_in_q,    comp_in_d;
    logic                 comp_start_q, comp_start_d;
    logic [PW-1:0]        tx_packet_q,  tx_packet_d;
    logic                 tx_enable_q,  tx_enable_d;
    logic                 busy_q,       busy_d;
    logic [TW-1:0]        timer_q,      timer_d;
    logic [WW-1:0]        wcnt_q,       wcnt_d;
    logic                 seen_q,       seen_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q,    pkt_cnt_d;

    logic rx_rise_s;
    logic overrun_inc_s;
    logic timeout_inc_s;

    // Only a fresh rising edge of rx_ready counts as a new packet; rx_prev
    // resets high so a level held through reset is not mistaken for one.
    assign rx_rise_s = rx_ready & ~rx_prev_q;

    // Next-state, datapath and pulse generation for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        rx_prev_d     = rx_ready;
        comp_in_d     = comp_in_q;
        comp_start_d  = 1'b0;
        tx_packet_d   = tx_packet_q;
        tx_enable_d   = 1'b0;
        timer_d       = timer_q;
        wcnt_d        = wcnt_q;
        seen_d        = seen_q;
        pkt_cnt_d     = pkt_cnt_q;
        timeout_inc_s = 1'b0;
        // A new packet arriving while a job is in flight is dropped.
        overrun_inc_s = rx_rise_s && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (rx_rise_s) begin
                    comp_in_d    = rx_packet;
                    comp_start_d = 1'b1;
                    timer_d      = {TW{1'b0}};
                    state_d      = ST_COMPUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (comp_done) begin
                    tx_packet_d = comp_out;
                    state_d     = ST_SEND;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_inc_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_SEND: begin
                // The sender may stay busy indefinitely; no timeout here.
                if (!tx_busy) begin
                    tx_enable_d = 1'b1;
                    wcnt_d      = {WW{1'b0}};
                    seen_d      = 1'b0;
                    state_d     = ST_DRAIN;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DRAIN: begin
                // Done when busy has been seen and dropped, or when the sender
                // never raised busy within the start window.
                if (seen_q && !tx_busy) begin
                    pkt_cnt_d = pkt_cnt_q + PKT_ONE;
                    state_d   = ST_IDLE;
                end else if (!seen_q && (wcnt_q == WCNT_LAST)) begin
                    pkt_cnt_d = pkt_cnt_q + PKT_ONE;
                    state_d   = ST_IDLE;
                end else begin
                    if (tx_busy) begin
                        seen_d = 1'b1;
                    end else begin
                        seen_d = seen_q;
                    end
                    if (!seen_q) begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end else begin
                        wcnt_d = wcnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, packet and counter registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rx_prev_q    <= 1'b1;
            comp_in_q    <= {PW{1'b0}};
            comp_start_q <= 1'b0;
            tx_packet_q  <= {PW{1'b0}};
            tx_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            timer_q      <= {TW{1'b0}};
            wcnt_q       <= {WW{1'b0}};
            seen_q       <= 1'b0;
            pkt_cnt_q    <= {PKT_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_prev_d;
            comp_in_q    <= comp_in_d;
            comp_start_q <= comp_start_d;
            tx_packet_q  <= tx_packet_d;
            tx_enable_q  <= tx_enable_d;
            busy_q       <= busy_d;
            timer_q      <= timer_d;
            wcnt_q       <= wcnt_d;
            seen_q       <= seen_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_overrun_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (overrun_inc_s),
        .count (overrun_cnt)
    );

    sat_counter #(.W(ERR_CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (timeout_inc_s),
        .count (timeout_cnt)
    );

    assign comp_in    = comp_in_q;
    assign comp_start = comp_start_q;
    assign tx_packet  = tx_packet_q;
    assign tx_enable  = tx_enable_q;
    assign busy       = busy_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_offload_sequencer.sv
// Directed bench for offload_sequencer: nominal job, timeout, overrun,
// sender backpressure, reset mid-job, first-cycle done, stray done, saturation.
module tb_offload_sequencer;

    localparam int PS = 15;
    localparam int PW = 8 * PS;
    // Core latency in the nominal job stays below the 16-cycle compute timeout.
    localparam int CORE_LAT = 12;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] rx_packet;
    logic          rx_ready;
    logic [PW-1:0] comp_in;
    logic          comp_start;
    logic [PW-1:0] comp_out;
    logic          comp_done;
    logic [PW-1:0] tx_packet;
    logic          tx_enable;
    logic          tx_busy;
    logic          busy;
    logic [15:0]   pkt_cnt;
    logic [7:0]    overrun_cnt;
    logic [7:0]    timeout_cnt;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int start_cnt = 0;
    int ten_cnt   = 0;

    logic [PW-1:0] p1, r1, pa, pb, ca, c4, c6, c7;

    offload_sequencer #(
        .PACKET_SIZE   (PS),
        .COMP_TIMEOUT  (16),
        .TX_START_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_packet   (rx_packet),
        .rx_ready    (rx_ready),
        .comp_in     (comp_in),
        .comp_start  (comp_start),
        .comp_out    (comp_out),
        .comp_done   (comp_done),
        .tx_packet   (tx_packet),
        .tx_enable   (tx_enable),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt),
        .overrun_cnt (overrun_cnt),
        .timeout_cnt (timeout_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] rev_bytes(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        for (int i = 0; i < PS; i++) begin
            r[8*i +: 8] = p[8*(PS-1-i) +: 8];
        end
        return r;
    endfunction

    // Advance one clock, land 1 ns after the edge, and tally output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (comp_start === 1'b1) start_cnt++;
        if (tx_enable === 1'b1) ten_cnt++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output is back at its reset value.
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},        128'(busy),        128'(1'b0));
        chk({tag, "_comp_start"},  128'(comp_start),  128'(1'b0));
        chk({tag, "_tx_enable"},   128'(tx_enable),   128'(1'b0));
        chk({tag, "_comp_in"},     128'(comp_in),     128'(1'b0));
        chk({tag, "_tx_packet"},   128'(tx_packet),   128'(1'b0));
        chk({tag, "_pkt_cnt"},     128'(pkt_cnt),     128'(1'b0));
        chk({tag, "_overrun_cnt"}, 128'(overrun_cnt), 128'(1'b0));
        chk({tag, "_timeout_cnt"}, 128'(timeout_cnt), 128'(1'b0));
    endtask

    initial begin
        p1 = "this is a test ";
        r1 = rev_bytes(p1);
        pa = {15{8'hA5}};
        pb = {15{8'h5A}};
        ca = {15{8'h3C}};
        c4 = {15{8'h44}};
        c6 = {15{8'h66}};
        c7 = {15{8'h77}};

        rst_n     = 1'b0;
        rx_packet = {PW{1'b0}};
        rx_ready  = 1'b0;
        comp_out  = {PW{1'b0}};
        comp_done = 1'b0;
        tx_busy   = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: nominal job, core returns byte-reversed packet.
        rx_packet = p1;
        rx_ready  = 1'b1;
        tick();
        chk("t1_comp_start", 128'(comp_start), 128'(1'b1));
        chk("t1_comp_in",    128'(comp_in),    128'(p1));
        chk("t1_busy",       128'(busy),       128'(1'b1));
        rx_ready = 1'b0;
        tick();
        chk("t1_start_pulse_end", 128'(comp_start), 128'(1'b0));
        repeat (CORE_LAT - 2) tick();
        comp_done = 1'b1;
        comp_out  = r1;
        tick();
        comp_done = 1'b0;
        chk("t1_tx_packet",   128'(tx_packet), 128'(r1));
        chk("t1_tx_en_early", 128'(tx_enable), 128'(1'b0));
        tick();
        chk("t1_tx_enable", 128'(tx_enable), 128'(1'b1));
        tx_busy = 1'b1;
        repeat (5) tick();
        chk("t1_busy_in_drain", 128'(busy), 128'(1'b1));
        tx_busy = 1'b0;
        tick();
        chk("t1_idle",      128'(busy),      128'(1'b0));
        chk("t1_pkt_cnt",   128'(pkt_cnt),   128'(16'd1));
        chk("t1_ten_cnt",   128'(ten_cnt),   128'(1));
        chk("t1_start_cnt", 128'(start_cnt), 128'(1));

        // 2: compute timeout after 16 cycles in COMPUTE.
        rx_packet = pa;
        rx_ready  = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t2_start_cnt", 128'(start_cnt), 128'(2));
        repeat (15) tick();
        chk("t2_still_busy", 128'(busy), 128'(1'b1));
        tick();
        chk("t2_idle",        128'(busy),        128'(1'b0));
        chk("t2_timeout_cnt", 128'(timeout_cnt), 128'(8'd1));
        chk("t2_no_tx",       128'(ten_cnt),     128'(1));

        // 3: overrun during COMPUTE and during DRAIN.
        rx_packet = pa;
        rx_ready  = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (2) tick();
        rx_packet = pb;
        rx_ready  = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t3_overrun1", 128'(overrun_cnt), 128'(8'd1));
        chk("t3_comp_in",  128'(comp_in),     128'(pa));
        comp_done = 1'b1;
        comp_out  = ca;
        tick();
        comp_done = 1'b0;
        tick();
        chk("t3_tx_enable", 128'(tx_enable), 128'(1'b1));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t3_overrun2", 128'(overrun_cnt), 128'(8'd2));
        repeat (3) tick();
        chk("t3_idle",      128'(busy),      128'(1'b0));
        chk("t3_pkt_cnt",   128'(pkt_cnt),   128'(16'd2));
        chk("t3_ten_cnt",   128'(ten_cnt),   128'(2));
        chk("t3_start_cnt", 128'(start_cnt), 128'(3));
        chk("t3_comp_in2",  128'(comp_in),   128'(pa));
        chk("t3_tx_packet", 128'(tx_packet), 128'(ca));

        // 4: sender busy 50 cycles at SEND, then never raises busy.
        tx_busy   = 1'b1;
        rx_packet = pb;
        rx_ready  = 1'b1;
        tick();
        rx_ready  = 1'b0;
        comp_done = 1'b1;
        comp_out  = c4;
        tick();
        comp_done = 1'b0;
        repeat (50) tick();
        chk("t4_held_no_tx", 128'(ten_cnt), 128'(2));
        chk("t4_held_busy",  128'(busy),    128'(1'b1));
        tx_busy = 1'b0;
        tick();
        chk("t4_tx_enable", 128'(tx_enable), 128'(1'b1));
        repeat (3) tick();
        chk("t4_drain_wait", 128'(busy), 128'(1'b1));
        tick();
        chk("t4_idle",    128'(busy),    128'(1'b0));
        chk("t4_pkt_cnt", 128'(pkt_cnt), 128'(16'd3));
        chk("t4_ten_cnt", 128'(ten_cnt), 128'(3));

        // 5: reset mid-COMPUTE with rx_ready held high through release.
        rx_packet = p1;
        rx_ready  = 1'b1;
        tick();
        chk("t5_comp_start", 128'(comp_start), 128'(1'b1));
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("t5_rst");
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t5_no_start",     128'(start_cnt), 128'(5));
        chk("t5_idle_release", 128'(busy),      128'(1'b0));
        rx_ready = 1'b0;
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t5_restart",  128'(comp_start), 128'(1'b1));
        chk("t5_comp_in",  128'(comp_in),    128'(p1));
        repeat (16) tick();
        chk("t5_timeout_idle", 128'(busy),        128'(1'b0));
        chk("t5_timeout_cnt",  128'(timeout_cnt), 128'(8'd1));
        chk("t5_no_tx",        128'(ten_cnt),     128'(3));

        // 6a: comp_done in the first COMPUTE cycle.
        rx_packet = pb;
        rx_ready  = 1'b1;
        tick();
        rx_ready  = 1'b0;
        comp_done = 1'b1;
        comp_out  = c6;
        tick();
        comp_done = 1'b0;
        chk("t6_first_done_pkt",  128'(tx_packet), 128'(c6));
        chk("t6_first_done_busy", 128'(busy),      128'(1'b1));
        tick();
        chk("t6_tx_enable", 128'(tx_enable), 128'(1'b1));
        repeat (4) tick();
        chk("t6_pkt_cnt", 128'(pkt_cnt), 128'(16'd1));
        chk("t6_ten_cnt", 128'(ten_cnt), 128'(4));

        // 6b: stray comp_done while idle changes nothing.
        comp_done = 1'b1;
        comp_out  = c7;
        tick();
        comp_done = 1'b0;
        tick();
        chk("t6_stray_busy",   128'(busy),       128'(1'b0));
        chk("t6_stray_tx_pkt", 128'(tx_packet),  128'(c6));
        chk("t6_stray_pkt",    128'(pkt_cnt),    128'(16'd1));
        chk("t6_stray_start",  128'(comp_start), 128'(1'b0));

        // 6c: 260 more timeouts; counter climbs to 255 and sticks.
        for (int i = 1; i <= 260; i++) begin
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            repeat (16) tick();
            if (i == 253) chk("t6_timeout_254", 128'(timeout_cnt), 128'(8'd254));
        end
        chk("t6_timeout_sat", 128'(timeout_cnt), 128'(8'd255));
        chk("t6_sat_idle",    128'(busy),        128'(1'b0));
        chk("t6_sat_no_tx",   128'(ten_cnt),     128'(4));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
